// File: rtl/kernel_sequencer.sv
// Sequences a 9-lane XNOR-popcount kernel over an arbitrary-length binary dot product.
// Latency: last beat cycle -> DRAIN -> result valid in the following cycle; a len=0 job reaches DONE one cycle after start.
// Backpressure: start accepted only in IDLE, chunks only in RUN; the result is held in DONE until res_ready_in.
// Optional busy-cycle counter is built when KSEQ_PERF_EN is defined.
module kernel_sequencer #(
  parameter int LEN_W = 12,
  parameter int ACC_W = 16
`ifdef KSEQ_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_valid_in,
  output logic              start_ready_out,
  input  logic [LEN_W-1:0]  start_len_in,
  input  logic              in_valid_in,
  output logic              in_ready_out,
  input  logic [8:0]        in_act_in,
  input  logic [8:0]        in_wgt_in,
  output logic [8:0]        kern_act_out,
  output logic [8:0]        kern_wgt_out,
  output logic [3:0]        kern_skip_out,
  input  logic [4:0]        kern_psum_in,
  output logic              res_valid_out,
  input  logic              res_ready_in,
`ifdef KSEQ_PERF_EN
  output logic [PERF_W-1:0] busy_cycles_out,
`endif
  output logic [ACC_W-1:0]  res_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   rem_q;
  logic [LEN_W-1:0]   rem_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_d;
  logic               issue_d;
  logic               beat;
  logic               start_acc;
  logic               last_chunk;
  logic [8:0]         lane_mask;
  logic [ACC_W-1:0]   psum_ext;

  // The kernel psum is signed 5-bit; widen it to the accumulator width.
  assign psum_ext = {{(ACC_W-5){kern_psum_in[4]}}, kern_psum_in};

  // Next-state, datapath updates and all combinational outputs.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    acc_d           = acc_q;
    start_ready_out = (state_q == IDLE);
    in_ready_out    = (state_q == RUN);
    res_valid_out   = (state_q == DONE);
    res_data_out    = acc_q;
    beat            = in_valid_in && (state_q == RUN);
    start_acc       = start_valid_in && (state_q == IDLE);
    last_chunk      = (rem_q <= LEN_W'(9));
    kern_act_out    = '0;
    kern_wgt_out    = '0;
    kern_skip_out   = '0;

    // Lanes at or beyond the remaining bit count are padding. For rem > 9
    // every lane is below rem, so the mask is all-ones for full chunks.
    lane_mask = '0;
    for (int i = 0; i < 9; i++) begin
      lane_mask[i] = (LEN_W'(i) < rem_q);
    end

    // A psum issued last cycle belongs to this job (RUN or DRAIN).
    if (issue_d) begin
      acc_d = acc_q + psum_ext;
    end

    case (state_q)
      IDLE: begin
        if (start_acc) begin
          rem_d = start_len_in;
          acc_d = '0;
          if (start_len_in == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          // Padded lanes are forced to act=0/wgt=0 so they count as matches;
          // the kernel subtracts them back out via skip.
          kern_act_out = in_act_in & lane_mask;
          kern_wgt_out = in_wgt_in & lane_mask;
          if (last_chunk) begin
            kern_skip_out = 4'd9 - rem_q[3:0];
            rem_d         = '0;
            state_d       = DRAIN;
          end else begin
            rem_d = rem_q - LEN_W'(9);
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        if (res_ready_in) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remaining length, accumulator and the one-cycle issue tracker that
  // lines accumulation up with the kernel's registered psum.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      rem_q   <= '0;
      acc_q   <= '0;
      issue_d <= 1'b0;
    end else begin
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      issue_d <= beat;
    end
  end

`ifdef KSEQ_PERF_EN
  // Busy-cycle counter: cleared on start, counts RUN/DRAIN/DONE cycles,
  // saturates, and holds its value while idle.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      busy_cycles_out <= '0;
    end else if (start_acc) begin
      busy_cycles_out <= '0;
    end else if ((state_q != IDLE) && (busy_cycles_out != {PERF_W{1'b1}})) begin
      busy_cycles_out <= busy_cycles_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_kernel_sequencer.sv
// Directed bench for kernel_sequencer with a behavioural XNOR-popcount kernel.
// Inputs change and outputs are sampled 1ns after the rising edge.
// Prints one summary line of passed/total checks.
module tb_kernel_sequencer;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_valid_in;
  logic        start_ready_out;
  logic [11:0] start_len_in;
  logic        in_valid_in;
  logic        in_ready_out;
  logic [8:0]  in_act_in;
  logic [8:0]  in_wgt_in;
  logic [8:0]  kern_act_out;
  logic [8:0]  kern_wgt_out;
  logic [3:0]  kern_skip_out;
  logic [4:0]  kern_psum_in;
  logic        res_valid_out;
  logic        res_ready_in;
  logic [15:0] res_data_out;
`ifdef KSEQ_PERF_EN
  logic [15:0] busy_cycles_out;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;

  kernel_sequencer dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .start_valid_in  (start_valid_in),
    .start_ready_out (start_ready_out),
    .start_len_in    (start_len_in),
    .in_valid_in     (in_valid_in),
    .in_ready_out    (in_ready_out),
    .in_act_in       (in_act_in),
    .in_wgt_in       (in_wgt_in),
    .kern_act_out    (kern_act_out),
    .kern_wgt_out    (kern_wgt_out),
    .kern_skip_out   (kern_skip_out),
    .kern_psum_in    (kern_psum_in),
    .res_valid_out   (res_valid_out),
    .res_ready_in    (res_ready_in),
`ifdef KSEQ_PERF_EN
    .busy_cycles_out (busy_cycles_out),
`endif
    .res_data_out    (res_data_out)
  );

  always #5 clk_in = ~clk_in;

  // Kernel model: psum = 2*popcount(xnor(act,wgt)) - 9 - skip, registered.
  always @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) kern_psum_in <= 5'd0;
    else kern_psum_in <= 5'(2 * $countones(~(kern_act_out ^ kern_wgt_out)) - 9 - int'(kern_skip_out));
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_start(input logic [11:0] len);
    start_valid_in = 1'b1;
    start_len_in   = len;
    tick();
    start_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    reset_in = 1'b0;
    start_valid_in = 0; start_len_in = 0; in_valid_in = 0;
    in_act_in = 0; in_wgt_in = 0; res_ready_in = 0;
    tick(); tick();
    check_cnt++;
    if (res_valid_out !== 1'b0) $display("FAIL reset_res_valid got=%b exp=0", res_valid_out); else pass_cnt++;
    check_cnt++;
    if (res_data_out !== 16'h0) $display("FAIL reset_res_data got=%h exp=0000", res_data_out); else pass_cnt++;
    check_cnt++;
    if ({kern_act_out, kern_wgt_out, kern_skip_out} !== 22'h0)
      $display("FAIL reset_kern got=%h/%h/%h exp=0", kern_act_out, kern_wgt_out, kern_skip_out); else pass_cnt++;
    check_cnt++;
    if (in_ready_out !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready_out); else pass_cnt++;
    reset_in = 1'b1;
    tick();
    check_cnt++;
    if (start_ready_out !== 1'b1) $display("FAIL idle_start_ready got=%b exp=1", start_ready_out); else pass_cnt++;
  endtask

  task automatic test_len9();
    do_start(12'd9);
    check_cnt++;
    if (in_ready_out !== 1'b1) $display("FAIL len9_in_ready got=%b exp=1", in_ready_out); else pass_cnt++;
    in_valid_in = 1; in_act_in = 9'h155; in_wgt_in = 9'h155;
    #1;
    check_cnt++;
    if (kern_skip_out !== 4'd0 || kern_act_out !== 9'h155)
      $display("FAIL len9_kern got=act %h skip %0d exp=act 155 skip 0", kern_act_out, kern_skip_out); else pass_cnt++;
    tick();
    in_valid_in = 0;
    check_cnt++;
    if (res_valid_out !== 1'b0) $display("FAIL len9_drain_valid got=%b exp=0", res_valid_out); else pass_cnt++;
    tick();
    check_cnt++;
    if (res_valid_out !== 1'b1 || res_data_out !== 16'd9)
      $display("FAIL len9_result got=v%b %h exp=v1 0009", res_valid_out, res_data_out); else pass_cnt++;
    check_cnt++;
    if (start_ready_out !== 1'b0) $display("FAIL len9_done_start_ready got=%b exp=0", start_ready_out); else pass_cnt++;
    res_ready_in = 1;
    tick();
    res_ready_in = 0;
    check_cnt++;
    if (res_valid_out !== 1'b0 || start_ready_out !== 1'b1)
      $display("FAIL len9_after_hs got=v%b sr%b exp=v0 sr1", res_valid_out, start_ready_out); else pass_cnt++;
  endtask

  task automatic test_tail_pad();
    logic [8:0] acts [3];
    logic [8:0] wgts [3];
    int n;
    acts[0] = 9'h1FF; wgts[0] = 9'h000;
    acts[1] = 9'h0AA; wgts[1] = 9'h0AA;
    acts[2] = 9'h1FD; wgts[2] = 9'h001;
    do_start(12'd20);
    for (int b = 0; b < 3; b++) begin
      in_valid_in = 1; in_act_in = acts[b]; in_wgt_in = wgts[b];
      #1;
      if (b == 0) begin
        check_cnt++;
        if (kern_skip_out !== 4'd0) $display("FAIL tail_full_skip got=%0d exp=0", kern_skip_out); else pass_cnt++;
      end
      if (b == 2) begin
        check_cnt++;
        if (kern_act_out !== 9'h001 || kern_wgt_out !== 9'h001 || kern_skip_out !== 4'd7)
          $display("FAIL tail_pad got=%h/%h/%0d exp=001/001/7", kern_act_out, kern_wgt_out, kern_skip_out); else pass_cnt++;
      end
      tick();
    end
    in_valid_in = 0;
    n = 0;
    while (!res_valid_out && n < 20) begin tick(); n++; end
    check_cnt++;
    if (res_valid_out !== 1'b1 || res_data_out !== 16'd2)
      $display("FAIL tail_result got=v%b %h exp=v1 0002", res_valid_out, res_data_out); else pass_cnt++;
    res_ready_in = 1; tick(); res_ready_in = 0;
  endtask

  task automatic test_len0();
    do_start(12'd0);
    check_cnt++;
    if (res_valid_out !== 1'b1 || res_data_out !== 16'd0 || in_ready_out !== 1'b0)
      $display("FAIL len0 got=v%b %h rdy%b exp=v1 0000 rdy0", res_valid_out, res_data_out, in_ready_out); else pass_cnt++;
    res_ready_in = 1; tick(); res_ready_in = 0;
  endtask

  task automatic test_gaps_backpressure();
    int n;
    do_start(12'd27);
    start_valid_in = 1; start_len_in = 12'd5;
    for (int k = 0; k < 6; k++) begin
      in_valid_in = (k % 2 == 1); in_act_in = 9'h1FF; in_wgt_in = 9'h000;
      #1;
      if (k % 2 == 0) begin
        check_cnt++;
        if ({kern_act_out, kern_wgt_out, kern_skip_out} !== 22'h0)
          $display("FAIL gap_kern_zero k=%0d got=%h/%h/%h exp=0", k, kern_act_out, kern_wgt_out, kern_skip_out); else pass_cnt++;
      end
      check_cnt++;
      if (start_ready_out !== 1'b0) $display("FAIL gap_start_ready k=%0d got=%b exp=0", k, start_ready_out); else pass_cnt++;
      tick();
    end
    start_valid_in = 0; in_valid_in = 0;
    n = 0;
    while (!res_valid_out && n < 20) begin tick(); n++; end
    for (int c = 0; c < 5; c++) begin
      in_valid_in = 1; in_act_in = 9'h0F0;
      check_cnt++;
      if (res_valid_out !== 1'b1 || res_data_out !== 16'hFFE5 || start_ready_out !== 1'b0)
        $display("FAIL gap_hold c=%0d got=v%b %h sr%b exp=v1 ffe5 sr0", c, res_valid_out, res_data_out, start_ready_out); else pass_cnt++;
      tick();
    end
    res_ready_in = 1; tick(); res_ready_in = 0; in_valid_in = 0;
    check_cnt++;
    if (res_valid_out !== 1'b0 || start_ready_out !== 1'b1)
      $display("FAIL gap_after_hs got=v%b sr%b exp=v0 sr1", res_valid_out, start_ready_out); else pass_cnt++;
  endtask

  task automatic test_reset_midjob();
    do_start(12'd30);
    in_valid_in = 1; in_act_in = 9'h1FF; in_wgt_in = 9'h1FF;
    tick(); tick();
    reset_in = 0;
    #2;
    check_cnt++;
    if ({res_valid_out, res_data_out, kern_act_out, kern_wgt_out, kern_skip_out, in_ready_out} !== 40'h0)
      $display("FAIL midreset_outputs got=v%b %h %h/%h/%h r%b exp=0", res_valid_out, res_data_out,
               kern_act_out, kern_wgt_out, kern_skip_out, in_ready_out); else pass_cnt++;
    tick();
    in_valid_in = 0;
    reset_in = 1;
    tick();
    do_start(12'd9);
    in_valid_in = 1; in_act_in = 9'h0F0; in_wgt_in = 9'h0FF;
    tick();
    in_valid_in = 0;
    tick();
    check_cnt++;
    if (res_valid_out !== 1'b1 || res_data_out !== 16'd1)
      $display("FAIL midreset_newjob got=v%b %h exp=v1 0001", res_valid_out, res_data_out); else pass_cnt++;
    res_ready_in = 1; tick(); res_ready_in = 0;
  endtask

  task automatic test_back_to_back();
    res_ready_in = 1;
    do_start(12'd18);
    in_valid_in = 1; in_act_in = 9'h1FF; in_wgt_in = 9'h1FF;
    tick();
    in_act_in = 9'h003; in_wgt_in = 9'h000;
    #1;
    check_cnt++;
    if (kern_skip_out !== 4'd0 || kern_act_out !== 9'h003)
      $display("FAIL b2b_second_kern got=act %h skip %0d exp=act 003 skip 0", kern_act_out, kern_skip_out); else pass_cnt++;
    tick();
    in_valid_in = 0;
    tick();
    check_cnt++;
    if (res_valid_out !== 1'b1 || res_data_out !== 16'd14)
      $display("FAIL b2b_result got=v%b %h exp=v1 000e", res_valid_out, res_data_out); else pass_cnt++;
    tick();
    res_ready_in = 0;
`ifdef KSEQ_PERF_EN
    check_cnt++;
    if (busy_cycles_out !== 16'd4) $display("FAIL perf_busy got=%0d exp=4", busy_cycles_out); else pass_cnt++;
    tick(); tick();
    check_cnt++;
    if (busy_cycles_out !== 16'd4) $display("FAIL perf_hold got=%0d exp=4", busy_cycles_out); else pass_cnt++;
`endif
    check_cnt++;
    if (res_valid_out !== 1'b0 || start_ready_out !== 1'b1)
      $display("FAIL b2b_after_hs got=v%b sr%b exp=v0 sr1", res_valid_out, start_ready_out); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_len9();
    test_tail_pad();
    test_len0();
    test_gaps_backpressure();
    test_reset_midjob();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
